// File: rtl/psu_pchinfo_buffer.sv
// Patch-info buffer between the patch-info producer and the PSU.
// Holds entries until a whole instruction is stored, then releases them first-word fall-through.
module psu_pchinfo_buffer #(
  parameter int PCHINFO_W = 40,
  parameter int OPCODE_W  = 6,
  parameter int DEPTH     = 16,
  parameter int SKID      = 2,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [PCHINFO_W-1:0] in_pchinfo,
  input  logic [OPCODE_W-1:0]  in_opcode,
  input  logic                 in_last,
  output logic                 stall_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PCHINFO_W-1:0] out_pchinfo,
  output logic [OPCODE_W-1:0]  out_opcode,
  output logic                 out_last,
  output logic [CNT_W-1:0]     occupancy,
  output logic [CNT_W-1:0]     instr_cnt,
  output logic                 overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PCHINFO_W-1:0] mem_pchinfo [DEPTH];
  logic [OPCODE_W-1:0]  mem_opcode  [DEPTH];
  logic [DEPTH-1:0]     mem_last;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] instr_q;
  logic             stall_q;
  logic             overflow_q;

  logic             has_data;
  logic             push;
  logic             pop;
  logic             drop;
  logic             instr_inc;
  logic             instr_dec;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] instr_next;
  logic             stall_next;
  logic             overflow_next;

  // Outputs read 0 while empty so stale storage never leaks out after reset.
  assign has_data    = (count != '0);
  assign out_valid   = has_data && (instr_q != '0);
  assign out_pchinfo = has_data ? mem_pchinfo[rd_ptr] : '0;
  assign out_opcode  = has_data ? mem_opcode[rd_ptr] : '0;
  assign out_last    = has_data ? mem_last[rd_ptr] : 1'b0;

  assign pop       = out_valid && out_ready;
  assign push      = in_valid && ((count < CNT_W'(DEPTH)) || pop);
  assign drop      = in_valid && !push;
  assign instr_inc = push && in_last;
  assign instr_dec = pop && out_last;

  always_comb begin
    count_next = count;
    instr_next = instr_q;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
    case ({instr_inc, instr_dec})
      2'b10:   instr_next = instr_q + CNT_W'(1);
      2'b01:   instr_next = instr_q - CNT_W'(1);
      default: instr_next = instr_q;
    endcase
  end

  // A full buffer with no complete instruction can never drain, so flag it as an error.
  assign stall_next    = (count_next >= CNT_W'(DEPTH - SKID));
  assign overflow_next = overflow_q || drop ||
                         ((count_next == CNT_W'(DEPTH)) && (instr_next == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      instr_q    <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= count_next;
      instr_q    <= instr_next;
      stall_q    <= stall_next;
      overflow_q <= overflow_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_pchinfo[wr_ptr] <= in_pchinfo;
      mem_opcode[wr_ptr]  <= in_opcode;
      mem_last[wr_ptr]    <= in_last;
    end
  end

  assign stall_out    = stall_q;
  assign occupancy    = count;
  assign instr_cnt    = instr_q;
  assign overflow_err = overflow_q;

endmodule

// File: doc/psu_pchinfo_buffer.md
Name: psu_pchinfo_buffer

Overview:
- Downstream neighbour of the patch-information stage. Sits between the patch-info producer and the PSU.
- Captures the per-patch info stream (pchinfo word, opcode, last-of-instruction flag) into a FIFO.
- Releases entries to the PSU only once a complete instruction's patch set is buffered.
- Produces a registered stall back to the producer. The stall has enough skid to absorb the producer's in-flight pipeline entries.

Parameters:
PCHINFO_W, 40, width of one patch-info word
OPCODE_W, 6, opcode width
DEPTH, 16, FIFO entries; power of two, >= 4
SKID, 2, entries reserved for producer in-flight data after stall asserts
CNT_W, $clog2(DEPTH)+1, width of occupancy/instruction counters

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  producer entry valid (producer's topsu valid)
in_pchinfo  in  PCHINFO_W  patch-info word
in_opcode  in  OPCODE_W  opcode accompanying the entry
in_last  in  1  entry is the last patch of its instruction
stall_out  out  1  registered stall to producer (drives its reg_stall)
out_valid  out  1  head entry available to PSU
out_ready  in  1  PSU accepts head entry
out_pchinfo  out  PCHINFO_W  head patch-info word
out_opcode  out  OPCODE_W  head opcode
out_last  out  1  head entry's last flag
occupancy  out  CNT_W  entries stored
instr_cnt  out  CNT_W  complete instructions stored (last flags in FIFO)
overflow_err  out  1  sticky: an entry was dropped

Behaviour:
- Reset values:
  - All outputs 0; out_pchinfo and out_opcode read 0.
  - Pointers 0.
  - Reset mid-operation discards all contents; the next cycle behaves as empty.
- Storage:
  - Circular buffer with wr_ptr and rd_ptr of log2(DEPTH) bits, wrapping modulo DEPTH.
  - Separate count register, 0..DEPTH.
- Push:
  - push = in_valid && (count < DEPTH || pop).
  - Data written at wr_ptr; wr_ptr increments.
  - in_valid while full with no pop: entry dropped, overflow_err set to 1 until rst.
- Pop:
  - pop = out_valid && out_ready; rd_ptr increments.
  - out_ready while out_valid=0 has no effect.
- Output path:
  - First-word fall-through: out_pchinfo, out_opcode and out_last show the entry at rd_ptr combinationally from storage.
  - out_valid = (count != 0) && (instr_cnt != 0). Partial instructions are never released.
- Counters:
  - count: +1 on push only, -1 on pop only, unchanged on both.
  - instr_cnt: +1 when a pushed entry has in_last=1; -1 when a popped entry has out_last=1; unchanged when both happen in the same cycle.
- Stall:
  - stall_out registered: next value = (count_next >= DEPTH-SKID), where count_next is this cycle's updated count.
  - It therefore asserts the cycle after occupancy reaches DEPTH-SKID.
  - The producer may still deliver up to SKID entries after assertion without overflow.
- Deadlock guard: if count_next == DEPTH and instr_cnt_next == 0 (instruction larger than buffer), overflow_err is set. stall_out still follows the rule above.
- Simultaneous push and pop when full is legal; count stays DEPTH.
- Latency: an entry pushed in cycle N is visible on the outputs in cycle N+1, provided its instruction is complete.

Test Plan:
- Single instruction of 3 entries (last on 3rd) with out_ready=1 → out_valid stays 0 during pushes 1–2. out_valid=1 the cycle after push 3. Three pops follow in order. instr_cnt goes 0→1→0 and occupancy returns to 0.
- out_ready=0; push 14 entries (DEPTH=16, SKID=2) with last on every 7th → stall_out=1 the cycle after the 14th push. Two further pushes are accepted, occupancy=16, overflow_err=0.
- Full FIFO, push and pop in the same cycle → occupancy stays 16. Entry order preserved across wrap (wr_ptr 15→0). out_pchinfo sequence matches input.
- Full FIFO, in_valid=1, out_ready=0 → entry dropped, overflow_err=1 and sticky; stored data unchanged.
- Push with in_last=1 while popping a last entry → instr_cnt unchanged (e.g., stays 2).
- Assert rst with 5 entries stored → next cycle: occupancy=0, instr_cnt=0, out_valid=0, stall_out=0, overflow_err=0.
